// File: rtl/alu_issue_queue_if.sv
// Bundle between rename/dispatch, the CDB and the ALU around the ALU issue queue.
// master: the surrounding pipeline; slave: the issue queue itself.
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

interface alu_issue_queue_if #(
  parameter int TAG_W = 7,
  parameter int ROB_W = $clog2(`ROB_LEN)
);
  logic             dis_valid;
  logic             dis_ready;
  logic [4:0]       dis_opcode;
  logic [2:0]       dis_funct3;
  logic             dis_funct7;
  logic [31:0]      dis_imm;
  logic [31:0]      dis_pc;
  logic [ROB_W-1:0] dis_rob_idx;
  logic [TAG_W-1:0] dis_rd;
  logic [TAG_W-1:0] dis_rs1_tag;
  logic [TAG_W-1:0] dis_rs2_tag;
  logic             dis_rs1_rdy;
  logic             dis_rs2_rdy;
  logic [31:0]      dis_rs1_data;
  logic [31:0]      dis_rs2_data;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             flush;
  logic             alu_i_valid;
  logic [4:0]       alu_opcode;
  logic [2:0]       alu_funct3;
  logic             alu_funct7;
  logic [31:0]      alu_rs1_data;
  logic [31:0]      alu_rs2_data;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_pc;
  logic [ROB_W-1:0] alu_i_rob_idx;
  logic [TAG_W-1:0] alu_i_rd;

  modport master (
    output dis_valid, dis_opcode, dis_funct3, dis_funct7, dis_imm, dis_pc, dis_rob_idx, dis_rd,
           dis_rs1_tag, dis_rs2_tag, dis_rs1_rdy, dis_rs2_rdy, dis_rs1_data, dis_rs2_data,
           cdb_valid, cdb_tag, cdb_data, flush,
    input  dis_ready, alu_i_valid, alu_opcode, alu_funct3, alu_funct7, alu_rs1_data,
           alu_rs2_data, alu_imm, alu_pc, alu_i_rob_idx, alu_i_rd
  );

  modport slave (
    input  dis_valid, dis_opcode, dis_funct3, dis_funct7, dis_imm, dis_pc, dis_rob_idx, dis_rd,
           dis_rs1_tag, dis_rs2_tag, dis_rs1_rdy, dis_rs2_rdy, dis_rs1_data, dis_rs2_data,
           cdb_valid, cdb_tag, cdb_data, flush,
    output dis_ready, alu_i_valid, alu_opcode, alu_funct3, alu_funct7, alu_rs1_data,
           alu_rs2_data, alu_imm, alu_pc, alu_i_rob_idx, alu_i_rd
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Out-of-order issue queue for the single integer ALU: captures operands from dispatch
// or CDB wakeups, selects the oldest ready entry each cycle and registers the ALU bundle.
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 7,
  parameter int ROB_W = $clog2(`ROB_LEN)
) (
  input logic          clk,
  input logic          rst,
  alu_issue_queue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob_idx;
    logic [TAG_W-1:0] rd;
  } uop_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rdy;
    logic [31:0]      data;
  } src_t;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] older [DEPTH];  // older[i][j]: entry i was dispatched before entry j
  uop_t             uop   [DEPTH];
  src_t             src1  [DEPTH];
  src_t             src2  [DEPTH];

  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] free_idx;
  logic             any_win;
  logic             issue;
  logic             dis_fire;
  logic             cdb_live;
  uop_t             dis_uop;
  src_t             dis_src1;
  src_t             dis_src2;

  uop_t             iss_uop;
  logic [31:0]      iss_rs1;
  logic [31:0]      iss_rs2;
  logic             iss_valid;

  function automatic src_t capture(input logic [TAG_W-1:0] tag, input logic rdy,
                                   input logic [31:0] data, input logic live,
                                   input logic [TAG_W-1:0] ctag, input logic [31:0] cdata);
    src_t s;
    s.tag  = tag;
    s.rdy  = rdy;
    s.data = data;
    if (!rdy && live && (tag == ctag)) begin
      s.rdy  = 1'b1;
      s.data = cdata;
    end
    return s;
  endfunction

  // Readiness comes from registered occupancy only; a same-cycle issue never frees a slot early.
  assign bus.dis_ready = ~&valid;
  assign dis_fire      = bus.dis_valid && bus.dis_ready && !bus.flush;
  assign cdb_live      = bus.cdb_valid && (bus.cdb_tag != '0);
  assign issue         = any_win && !bus.flush;

  assign dis_uop = '{opcode: bus.dis_opcode, funct3: bus.dis_funct3, funct7: bus.dis_funct7,
                     imm: bus.dis_imm, pc: bus.dis_pc, rob_idx: bus.dis_rob_idx, rd: bus.dis_rd};
  assign dis_src1 = capture(bus.dis_rs1_tag, bus.dis_rs1_rdy, bus.dis_rs1_data,
                            cdb_live, bus.cdb_tag, bus.cdb_data);
  assign dis_src2 = capture(bus.dis_rs2_tag, bus.dis_rs2_rdy, bus.dis_rs2_data,
                            cdb_live, bus.cdb_tag, bus.cdb_data);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    eligible = '0;
    win      = '0;
    win_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) eligible[i] = valid[i] && src1[i].rdy && src2[i].rdy;
    for (int i = 0; i < DEPTH; i++) begin
      win[i] = eligible[i];
      for (int j = 0; j < DEPTH; j++) if (eligible[j] && older[j][i]) win[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) if (win[i]) win_idx = IDX_W'(i);
    for (int i = DEPTH - 1; i >= 0; i--) if (!valid[i]) free_idx = IDX_W'(i);
  end

  assign any_win = |win;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (bus.flush) begin
      valid <= '0;
    end else begin
      if (any_win) valid[win_idx] <= 1'b0;
      if (dis_fire) begin
        valid[free_idx] <= 1'b1;
        older[free_idx] <= '0;
        for (int j = 0; j < DEPTH; j++) older[j][free_idx] <= valid[j];
      end
    end
  end

  // NOTE: entry payload has no reset; it is only observed while the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && cdb_live && !src1[i].rdy && (src1[i].tag == bus.cdb_tag)) begin
        src1[i].rdy  <= 1'b1;
        src1[i].data <= bus.cdb_data;
      end
      if (valid[i] && cdb_live && !src2[i].rdy && (src2[i].tag == bus.cdb_tag)) begin
        src2[i].rdy  <= 1'b1;
        src2[i].data <= bus.cdb_data;
      end
    end
    if (dis_fire) begin
      uop[free_idx]  <= dis_uop;
      src1[free_idx] <= dis_src1;
      src2[free_idx] <= dis_src2;
    end
  end

  // The issue bundle holds its data when nothing is selected; only the valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_uop   <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
    end else begin
      iss_valid <= issue;
      if (issue) begin
        iss_uop <= uop[win_idx];
        iss_rs1 <= src1[win_idx].data;
        iss_rs2 <= src2[win_idx].data;
      end
    end
  end

  assign bus.alu_i_valid   = iss_valid;
  assign bus.alu_opcode    = iss_uop.opcode;
  assign bus.alu_funct3    = iss_uop.funct3;
  assign bus.alu_funct7    = iss_uop.funct7;
  assign bus.alu_imm       = iss_uop.imm;
  assign bus.alu_pc        = iss_uop.pc;
  assign bus.alu_i_rob_idx = iss_uop.rob_idx;
  assign bus.alu_i_rd      = iss_uop.rd;
  assign bus.alu_rs1_data  = iss_rs1;
  assign bus.alu_rs2_data  = iss_rs2;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized traffic
// compared against an age-ordered queue model.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 7;
  localparam int ROB_W = 4;
  localparam logic [4:0] OP_I = 5'b00100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_queue_if #(.TAG_W(TAG_W), .ROB_W(ROB_W)) bus ();

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [4:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] rd;
  } bundle_t;

  typedef struct {
    bundle_t          b;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    bit               r1;
    bit               r2;
  } m_ent_t;

  // Reference model: entries in dispatch order, oldest at the front.
  m_ent_t  m_q[$];
  bit      m_valid;
  bundle_t m_b;

  bundle_t obs;
  assign obs = {bus.alu_opcode, bus.alu_funct3, bus.alu_funct7, bus.alu_rs1_data, bus.alu_rs2_data,
                bus.alu_imm, bus.alu_pc, bus.alu_i_rob_idx, bus.alu_i_rd};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dis_valid = 1'b0;    bus.dis_opcode = '0;   bus.dis_funct3 = '0;  bus.dis_funct7 = 1'b0;
    bus.dis_imm = '0;        bus.dis_pc = '0;       bus.dis_rob_idx = '0; bus.dis_rd = '0;
    bus.dis_rs1_tag = '0;    bus.dis_rs2_tag = '0;  bus.dis_rs1_rdy = 1'b0; bus.dis_rs2_rdy = 1'b0;
    bus.dis_rs1_data = '0;   bus.dis_rs2_data = '0;
    bus.cdb_valid = 1'b0;    bus.cdb_tag = '0;      bus.cdb_data = '0;    bus.flush = 1'b0;
  endtask

  task automatic set_dis(input logic [TAG_W-1:0] rd, input logic [ROB_W-1:0] rob,
                         input logic [TAG_W-1:0] t1, input logic r1, input logic [31:0] d1,
                         input logic [TAG_W-1:0] t2, input logic r2, input logic [31:0] d2,
                         input logic [31:0] imm);
    bus.dis_valid = 1'b1;  bus.dis_opcode = OP_I;  bus.dis_funct3 = rd[2:0]; bus.dis_funct7 = rd[0];
    bus.dis_imm = imm;     bus.dis_pc = 32'h1000 + 32'(rob) * 4;
    bus.dis_rob_idx = rob; bus.dis_rd = rd;
    bus.dis_rs1_tag = t1;  bus.dis_rs1_rdy = r1;   bus.dis_rs1_data = d1;
    bus.dis_rs2_tag = t2;  bus.dis_rs2_rdy = r2;   bus.dis_rs2_data = d2;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  // Advance the model by one clock edge using the inputs currently presented.
  task automatic m_step();
    bit     ready_pre;
    int     sel;
    m_ent_t e;
    ready_pre = (m_q.size() < DEPTH);
    if (bus.flush) begin
      m_q.delete();
      m_valid = 1'b0;
    end else begin
      sel = -1;
      foreach (m_q[i]) if (sel < 0 && m_q[i].r1 && m_q[i].r2) sel = i;
      m_valid = (sel >= 0);
      if (sel >= 0) begin
        m_b = m_q[sel].b;
        m_q.delete(sel);
      end
      if (bus.cdb_valid && bus.cdb_tag != 0) begin
        foreach (m_q[i]) begin
          e = m_q[i];
          if (!e.r1 && e.t1 == bus.cdb_tag) begin e.r1 = 1'b1; e.b.rs1_data = bus.cdb_data; end
          if (!e.r2 && e.t2 == bus.cdb_tag) begin e.r2 = 1'b1; e.b.rs2_data = bus.cdb_data; end
          m_q[i] = e;
        end
      end
      if (bus.dis_valid && ready_pre) begin
        e.b = {bus.dis_opcode, bus.dis_funct3, bus.dis_funct7, bus.dis_rs1_data, bus.dis_rs2_data,
               bus.dis_imm, bus.dis_pc, bus.dis_rob_idx, bus.dis_rd};
        e.t1 = bus.dis_rs1_tag;
        e.t2 = bus.dis_rs2_tag;
        e.r1 = bus.dis_rs1_rdy;
        e.r2 = bus.dis_rs2_rdy;
        if (!e.r1 && bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == e.t1) begin
          e.r1 = 1'b1; e.b.rs1_data = bus.cdb_data;
        end
        if (!e.r2 && bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == e.t2) begin
          e.r2 = 1'b1; e.b.rs2_data = bus.cdb_data;
        end
        m_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.alu_i_valid); else n_pass++;
    n_total++; if (bus.dis_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.dis_ready); else n_pass++;
    n_total++; if (obs !== '0) $display("FAIL reset_bundle: got %h want 0", obs); else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    // Three waiting entries plus one ready entry that is on the ALU port when reset hits.
    set_dis(7'd1, 4'd1, 7'd40, 1'b0, 32'd0, 7'd0, 1'b1, 32'd0, 32'd1); tick();
    set_dis(7'd2, 4'd2, 7'd41, 1'b0, 32'd0, 7'd0, 1'b1, 32'd0, 32'd2); tick();
    set_dis(7'd3, 4'd3, 7'd42, 1'b0, 32'd0, 7'd0, 1'b1, 32'd0, 32'd3); tick();
    set_dis(7'd10, 4'd4, 7'd0, 1'b1, 32'd11, 7'd0, 1'b1, 32'd0, 32'd4); tick();
    idle();
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b1 || bus.alu_i_rd !== 7'd10) $display("FAIL prereset_issue: valid %b rd %0d want 1 rd 10", bus.alu_i_valid, bus.alu_i_rd); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", bus.alu_i_valid); else n_pass++;
    n_total++; if (bus.dis_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", bus.dis_ready); else n_pass++;
    n_total++; if (bus.alu_i_rd !== '0 || bus.alu_rs1_data !== '0) $display("FAIL midreset_bundle: rd %0d rs1 %h want 0", bus.alu_i_rd, bus.alu_rs1_data); else n_pass++;
    #2;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_cdb(7'(40 + (k % 3)), 32'hdead0000 + 32'(k));
      tick();
      n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL postreset_quiet %0d: got %b want 0", k, bus.alu_i_valid); else n_pass++;
    end
    idle();
  endtask

  task automatic test_ready_dispatch();
    do_reset();
    set_dis(7'd17, 4'd6, 7'd3, 1'b1, 32'd5, 7'd0, 1'b1, 32'd0, 32'd3);
    tick();
    idle();
    n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL ready_latency: got %b want 0 after accept edge", bus.alu_i_valid); else n_pass++;
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b1) $display("FAIL ready_valid: got %b want 1", bus.alu_i_valid); else n_pass++;
    n_total++; if (bus.alu_rs1_data !== 32'd5 || bus.alu_imm !== 32'd3) $display("FAIL ready_data: rs1 %0d imm %0d want 5 3", bus.alu_rs1_data, bus.alu_imm); else n_pass++;
    n_total++; if (bus.alu_i_rd !== 7'd17 || bus.alu_i_rob_idx !== 4'd6) $display("FAIL ready_ids: rd %0d rob %0d want 17 6", bus.alu_i_rd, bus.alu_i_rob_idx); else n_pass++;
    n_total++; if (bus.alu_opcode !== OP_I || bus.alu_pc !== 32'h1018) $display("FAIL ready_op: op %h pc %h want %h 1018", bus.alu_opcode, bus.alu_pc, OP_I); else n_pass++;
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL ready_single: got %b want 0", bus.alu_i_valid); else n_pass++;
  endtask

  task automatic test_wakeup_order();
    do_reset();
    set_dis(7'd21, 4'd1, 7'd9, 1'b0, 32'd0, 7'd0, 1'b1, 32'd0, 32'd0); tick();
    set_dis(7'd22, 4'd2, 7'd0, 1'b1, 32'haa, 7'd0, 1'b1, 32'd0, 32'd0); tick();
    idle();
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b1 || bus.alu_i_rd !== 7'd22) $display("FAIL wake_b_first: valid %b rd %0d want 1 22", bus.alu_i_valid, bus.alu_i_rd); else n_pass++;
    set_cdb(7'd9, 32'h1234);
    tick();
    idle();
    n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL wake_not_early: got %b want 0", bus.alu_i_valid); else n_pass++;
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b1 || bus.alu_i_rd !== 7'd21) $display("FAIL wake_a_issue: valid %b rd %0d want 1 21", bus.alu_i_valid, bus.alu_i_rd); else n_pass++;
    n_total++; if (bus.alu_rs1_data !== 32'h1234) $display("FAIL wake_a_data: got %h want 1234", bus.alu_rs1_data); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    set_dis(7'd50, 4'd5, 7'd0, 1'b1, 32'd1, 7'd12, 1'b0, 32'd0, 32'd0);
    set_cdb(7'd12, 32'd7);
    tick();
    idle();
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b1 || bus.alu_i_rd !== 7'd50) $display("FAIL bypass_issue: valid %b rd %0d want 1 50", bus.alu_i_valid, bus.alu_i_rd); else n_pass++;
    n_total++; if (bus.alu_rs2_data !== 32'd7) $display("FAIL bypass_data: got %0d want 7", bus.alu_rs2_data); else n_pass++;
    // Tag 0 never wakes anything, neither at dispatch nor afterwards.
    set_dis(7'd51, 4'd6, 7'd0, 1'b0, 32'd0, 7'd0, 1'b1, 32'd0, 32'd0);
    set_cdb(7'd0, 32'd99);
    tick();
    bus.dis_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL tag0_nowake %0d: got %b want 0", k, bus.alu_i_valid); else n_pass++;
    end
    idle();
  endtask

  task automatic test_full_age();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_dis(7'(30 + k), 4'(k), 7'(20 + k), 1'b0, 32'd0, 7'd0, 1'b1, 32'(k), 32'(k));
      tick();
    end
    n_total++; if (bus.dis_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.dis_ready); else n_pass++;
    // A ready fifth op presented while full must be dropped.
    set_dis(7'd45, 4'd9, 7'd0, 1'b1, 32'd0, 7'd0, 1'b1, 32'd0, 32'd0);
    set_cdb(7'd23, 32'h23);
    tick();
    idle();
    n_total++; if (bus.dis_ready !== 1'b0 || bus.alu_i_valid !== 1'b0) $display("FAIL full_hold: ready %b valid %b want 0 0", bus.dis_ready, bus.alu_i_valid); else n_pass++;
    set_cdb(7'd20, 32'h20);
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b1 || bus.alu_i_rd !== 7'd33 || bus.alu_rs1_data !== 32'h23) $display("FAIL age_first: valid %b rd %0d rs1 %h want 1 33 23", bus.alu_i_valid, bus.alu_i_rd, bus.alu_rs1_data); else n_pass++;
    n_total++; if (bus.dis_ready !== 1'b1) $display("FAIL full_release: got %b want 1", bus.dis_ready); else n_pass++;
    set_cdb(7'd22, 32'h22);
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b1 || bus.alu_i_rd !== 7'd30 || bus.alu_rs1_data !== 32'h20) $display("FAIL age_second: valid %b rd %0d rs1 %h want 1 30 20", bus.alu_i_valid, bus.alu_i_rd, bus.alu_rs1_data); else n_pass++;
    set_cdb(7'd21, 32'h21);
    tick();
    idle();
    n_total++; if (bus.alu_i_valid !== 1'b1 || bus.alu_i_rd !== 7'd32) $display("FAIL b2b_third: valid %b rd %0d want 1 32", bus.alu_i_valid, bus.alu_i_rd); else n_pass++;
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b1 || bus.alu_i_rd !== 7'd31) $display("FAIL b2b_fourth: valid %b rd %0d want 1 31", bus.alu_i_valid, bus.alu_i_rd); else n_pass++;
    tick();
    n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL full_drop: got %b want 0", bus.alu_i_valid); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    set_dis(7'd61, 4'd1, 7'd50, 1'b0, 32'd0, 7'd0, 1'b1, 32'd0, 32'd0); tick();
    set_dis(7'd62, 4'd2, 7'd51, 1'b0, 32'd0, 7'd0, 1'b1, 32'd0, 32'd0); tick();
    set_dis(7'd59, 4'd3, 7'd0, 1'b1, 32'd8, 7'd0, 1'b1, 32'd0, 32'd0); tick();
    set_dis(7'd60, 4'd4, 7'd0, 1'b1, 32'd9, 7'd0, 1'b1, 32'd0, 32'd0);
    set_cdb(7'd50, 32'd5);
    bus.flush = 1'b1;
    tick();
    idle();
    n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.alu_i_valid); else n_pass++;
    n_total++; if (bus.dis_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", bus.dis_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      set_cdb(7'(50 + (k % 2)), 32'd100);
      tick();
      n_total++; if (bus.alu_i_valid !== 1'b0) $display("FAIL flush_quiet %0d: got %b want 0", k, bus.alu_i_valid); else n_pass++;
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_b = '0;
    for (int c = 0; c < 600; c++) begin
      bus.dis_valid    = ($urandom_range(0, 9) < 6);
      bus.dis_opcode   = 5'($urandom);
      bus.dis_funct3   = 3'($urandom);
      bus.dis_funct7   = 1'($urandom);
      bus.dis_imm      = $urandom;
      bus.dis_pc       = $urandom;
      bus.dis_rob_idx  = 4'($urandom);
      bus.dis_rd       = 7'($urandom);
      bus.dis_rs1_tag  = 7'($urandom_range(0, 7));
      bus.dis_rs2_tag  = 7'($urandom_range(0, 7));
      bus.dis_rs1_rdy  = 1'($urandom);
      bus.dis_rs2_rdy  = 1'($urandom);
      bus.dis_rs1_data = $urandom;
      bus.dis_rs2_data = $urandom;
      bus.cdb_valid    = 1'($urandom);
      bus.cdb_tag      = 7'($urandom_range(0, 7));
      bus.cdb_data     = $urandom;
      bus.flush        = ($urandom_range(0, 49) == 0);
      m_step();
      tick();
      n_total++;
      if (bus.alu_i_valid !== m_valid || bus.dis_ready !== (m_q.size() < DEPTH) || (m_valid && obs !== m_b))
        $display("FAIL random cycle %0d: valid %b want %b, ready %b want %b, bundle %h want %h",
                 c, bus.alu_i_valid, m_valid, bus.dis_ready, (m_q.size() < DEPTH), obs, m_b);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_wakeup_order();
    test_bypass();
    test_full_age();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
